// File: rtl/dcache_flush_ctrl.sv
// Full write-back dcache flush sequencer: walks every set, writes back dirty ways, then invalidates the set.
// Optional writeback counter output flush_wb_cnt_o is enabled by defining DCACHE_FLUSH_PERF_EN.
module dcache_flush_ctrl #(
  parameter int NUM_SETS = 256,
  parameter int NUM_WAYS = 8,
  localparam int SET_W = $clog2(NUM_SETS),
  localparam int WAY_W = $clog2(NUM_WAYS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_req_i,
  output logic                flush_ack_o,
  output logic                busy_o,
`ifdef DCACHE_FLUSH_PERF_EN
  output logic [SET_W+WAY_W:0] flush_wb_cnt_o,
`endif
  output logic                tag_req_o,
  output logic [SET_W-1:0]    tag_set_o,
  input  logic                tag_gnt_i,
  input  logic [NUM_WAYS-1:0] valid_i,
  input  logic [NUM_WAYS-1:0] dirty_i,
  output logic                wb_req_o,
  output logic [WAY_W-1:0]    wb_way_o,
  input  logic                wb_gnt_i,
  input  logic                wb_done_i,
  output logic                clr_req_o,
  input  logic                clr_gnt_i
);

  typedef enum logic [2:0] {
    IDLE,
    RD_TAG,
    CHK,
    WB,
    WB_WAIT,
    CLR,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [SET_W-1:0]    setCnt_q, setCnt_d;
  logic [NUM_WAYS-1:0] mask_q, mask_d;
  logic [WAY_W-1:0]    wbWay;
  logic [NUM_WAYS-1:0] wbWayOneHot;

  // Lowest pending way wins, so the loop runs high to low and the last hit sticks.
  always_comb begin
    wbWay = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (mask_q[i]) wbWay = WAY_W'(i);
    end
  end

  assign wbWayOneHot = NUM_WAYS'(1) << wbWay;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      setCnt_q <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      setCnt_q <= setCnt_d;
      mask_q   <= mask_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    setCnt_d = setCnt_q;
    mask_d   = mask_q;
    case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          state_d  = RD_TAG;
          setCnt_d = '0;
        end
      end
      RD_TAG: begin
        if (tag_gnt_i) state_d = CHK;
      end
      CHK: begin
        mask_d = valid_i & dirty_i;
        if ((valid_i & dirty_i) != '0) state_d = WB;
        else                           state_d = CLR;
      end
      WB: begin
        if (wb_gnt_i) state_d = WB_WAIT;
      end
      WB_WAIT: begin
        if (wb_done_i) begin
          mask_d = mask_q & ~wbWayOneHot;
          if ((mask_q & ~wbWayOneHot) != '0) state_d = WB;
          else                               state_d = CLR;
        end
      end
      CLR: begin
        if (clr_gnt_i) begin
          if (setCnt_q == SET_W'(NUM_SETS - 1)) begin
            state_d = DONE;
          end else begin
            setCnt_d = setCnt_q + SET_W'(1);
            state_d  = RD_TAG;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign tag_req_o   = (state_q == RD_TAG);
  assign wb_req_o    = (state_q == WB);
  assign clr_req_o   = (state_q == CLR);
  assign flush_ack_o = (state_q == DONE);
  assign tag_set_o   = setCnt_q;
  assign wb_way_o    = wbWay;

`ifdef DCACHE_FLUSH_PERF_EN
  logic [SET_W+WAY_W:0] wbCnt_q, wbCnt_d;

  // Counts completed writebacks of the current flush; holds after DONE until the next start.
  always_comb begin
    wbCnt_d = wbCnt_q;
    if (state_q == IDLE && flush_req_i) begin
      wbCnt_d = '0;
    end else if (state_q == WB_WAIT && wb_done_i) begin
      wbCnt_d = wbCnt_q + (SET_W+WAY_W+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) wbCnt_q <= '0;
    else       wbCnt_q <= wbCnt_d;
  end

  assign flush_wb_cnt_o = wbCnt_q;
`else
`endif

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Self-checking bench for dcache_flush_ctrl: a cycle-level vector table plus directed multi-cycle sequences.
// Perf-counter checks are compiled in only when DCACHE_FLUSH_PERF_EN is defined.
module tb_dcache_flush_ctrl;

  localparam int NUM_SETS = 256;
  localparam int NUM_WAYS = 8;
  localparam int SET_W    = 8;
  localparam int WAY_W    = 3;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                rst_i      = 1'b1;
  logic                flushReq   = 1'b0;
  logic                tagGnt     = 1'b0;
  logic                wbGnt      = 1'b0;
  logic                clrGnt     = 1'b0;
  logic                tbWbDone   = 1'b0;
  logic [NUM_WAYS-1:0] tbValid    = '0;
  logic [NUM_WAYS-1:0] tbDirty    = '0;
  logic                autoMode   = 1'b0;

  logic                flushAck, busy, tagReq, wbReq, clrReq;
  logic [SET_W-1:0]    tagSet;
  logic [WAY_W-1:0]    wbWay;
  logic [NUM_WAYS-1:0] validIn, dirtyIn, modelValid, modelDirty;
  logic                wbDoneIn, autoDone;
  logic [2:0]          doneTimer = 3'd0;
`ifdef DCACHE_FLUSH_PERF_EN
  logic [SET_W+WAY_W:0] wbCnt;
`endif

  int passCnt  = 0;
  int totalCnt = 0;

  dcache_flush_ctrl #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_req_i (flushReq),
    .flush_ack_o (flushAck),
    .busy_o      (busy),
`ifdef DCACHE_FLUSH_PERF_EN
    .flush_wb_cnt_o (wbCnt),
`endif
    .tag_req_o   (tagReq),
    .tag_set_o   (tagSet),
    .tag_gnt_i   (tagGnt),
    .valid_i     (validIn),
    .dirty_i     (dirtyIn),
    .wb_req_o    (wbReq),
    .wb_way_o    (wbWay),
    .wb_gnt_i    (wbGnt),
    .wb_done_i   (wbDoneIn),
    .clr_req_o   (clrReq),
    .clr_gnt_i   (clrGnt)
  );

  // Tag-array contents for the automatic runs: set 0 dirty-but-invalid, set 5 two dirty ways, set 100 one.
  always_comb begin
    modelValid = 8'h00;
    modelDirty = 8'h00;
    if (tagSet == 8'd0) begin
      modelValid = 8'h00;
      modelDirty = 8'h01;
    end else if (tagSet == 8'd5) begin
      modelValid = 8'hFF;
      modelDirty = 8'h44;
    end else if (tagSet == 8'd100) begin
      modelValid = 8'h03;
      modelDirty = 8'h01;
    end
  end

  // Miss unit model: wb_done pulses 4 cycles after each accepted writeback.
  always @(posedge clk_i) begin
    if (!autoMode)                 doneTimer <= 3'd0;
    else if (wbReq && wbGnt)       doneTimer <= 3'd4;
    else if (doneTimer != 3'd0)    doneTimer <= doneTimer - 3'd1;
  end

  assign autoDone = (doneTimer == 3'd1);
  assign validIn  = autoMode ? modelValid : tbValid;
  assign dirtyIn  = autoMode ? modelDirty : tbDirty;
  assign wbDoneIn = autoMode ? autoDone   : tbWbDone;

  typedef struct {
    logic [4:0] ctl;   // {flush_req, tag_gnt, clr_gnt, wb_gnt, wb_done}
    logic [7:0] v;
    logic [7:0] d;
    logic [4:0] exp;   // {busy, tag_req, wb_req, clr_req, flush_ack}
    logic [7:0] eSet;
    logic [2:0] eWay;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCnt++;
    if (actual === expected) passCnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input vec_t v);
    {flushReq, tagGnt, clrGnt, wbGnt, tbWbDone} = v.ctl;
    tbValid = v.v;
    tbDirty = v.d;
    tick();
  endtask

  task automatic doReset();
    rst_i    = 1'b1;
    autoMode = 1'b0;
    {flushReq, tagGnt, clrGnt, wbGnt, tbWbDone} = 5'b0;
    tbValid  = '0;
    tbDirty  = '0;
    tick();
    rst_i = 1'b0;
  endtask

  function automatic logic [4:0] outVec();
    return {busy, tagReq, wbReq, clrReq, flushAck};
  endfunction

  initial begin : main
    int cyc;
    int clrCnt;
    int wbAll;
    int wbHs5;
    int set5Cyc;
    int done5;
    int done5AtClr;
    bit orderOk;
    bit wbSeen;
    bit stableOk;
    bit quietOk;
    logic [2:0] ways5[2];

    vecs[0]  = '{5'b10000, 8'h00, 8'h00, 5'b00000, 8'd0, 3'd0};
    vecs[1]  = '{5'b00000, 8'h00, 8'h00, 5'b11000, 8'd0, 3'd0};
    vecs[2]  = '{5'b01000, 8'h00, 8'h00, 5'b11000, 8'd0, 3'd0};
    vecs[3]  = '{5'b00000, 8'h00, 8'h01, 5'b10000, 8'd0, 3'd0};
    vecs[4]  = '{5'b00100, 8'h00, 8'h00, 5'b10010, 8'd0, 3'd0};
    vecs[5]  = '{5'b01000, 8'h00, 8'h00, 5'b11000, 8'd1, 3'd0};
    vecs[6]  = '{5'b00000, 8'hFF, 8'h81, 5'b10000, 8'd1, 3'd0};
    vecs[7]  = '{5'b00000, 8'h00, 8'h00, 5'b10100, 8'd1, 3'd0};
    vecs[8]  = '{5'b00010, 8'h00, 8'h00, 5'b10100, 8'd1, 3'd0};
    vecs[9]  = '{5'b00001, 8'h00, 8'h00, 5'b10000, 8'd1, 3'd0};
    vecs[10] = '{5'b00001, 8'h00, 8'h00, 5'b10100, 8'd1, 3'd7};
    vecs[11] = '{5'b00010, 8'h00, 8'h00, 5'b10100, 8'd1, 3'd7};
    vecs[12] = '{5'b00001, 8'h00, 8'h00, 5'b10000, 8'd1, 3'd0};
    vecs[13] = '{5'b00100, 8'h00, 8'h00, 5'b10010, 8'd1, 3'd0};
    vecs[14] = '{5'b00000, 8'h00, 8'h00, 5'b11000, 8'd2, 3'd0};

    tick();
    doReset();
`ifdef DCACHE_FLUSH_PERF_EN
    checkOutput("reset_wbcnt", 32'(wbCnt), 32'd0);
`endif
    checkOutput("reset_way", 32'(wbWay), 32'd0);

    // Vector table: valid masking at set 0, tag stall, two writebacks at set 1, wb_done ignored in WB.
    for (int i = 0; i < 15; i++) begin
      checkOutput($sformatf("row%0d_outs", i), 32'(outVec()), 32'(vecs[i].exp));
      checkOutput($sformatf("row%0d_set", i), 32'(tagSet), 32'(vecs[i].eSet));
      if (vecs[i].exp[2]) checkOutput($sformatf("row%0d_way", i), 32'(wbWay), 32'(vecs[i].eWay));
      applyStimulus(vecs[i]);
    end

    // Clean flush, grants tied high.
    doReset();
    {tagGnt, wbGnt, clrGnt} = 3'b111;
    flushReq = 1'b1;
    tick();
    flushReq = 1'b0;
    checkOutput("clean_busy_rise", 32'(busy), 32'd1);
    cyc = 0; clrCnt = 0; orderOk = 1'b1; wbSeen = 1'b0;
    while (!flushAck && cyc < 2000) begin
      if (clrReq) begin
        if (tagSet != 8'(clrCnt)) orderOk = 1'b0;
        clrCnt++;
      end
      if (wbReq) wbSeen = 1'b1;
      tick();
      cyc++;
    end
    checkOutput("clean_ack_seen", 32'(flushAck), 32'd1);
    checkOutput("clean_ack_latency", 32'(cyc), 32'd768);
    checkOutput("clean_clr_count", 32'(clrCnt), 32'd256);
    checkOutput("clean_set_order", 32'(orderOk), 32'd1);
    checkOutput("clean_no_wb", 32'(wbSeen), 32'd0);
    tick();
    checkOutput("clean_ack_pulse", 32'(outVec()), 32'd0);

    // Dirty sets with the automatic tag array and miss unit.
    doReset();
    autoMode = 1'b1;
    {tagGnt, wbGnt, clrGnt} = 3'b111;
    flushReq = 1'b1;
    tick();
    flushReq = 1'b0;
    cyc = 0; wbAll = 0; wbHs5 = 0; set5Cyc = 0; done5 = 0; done5AtClr = -1;
    ways5[0] = 3'd0; ways5[1] = 3'd0;
    while (!flushAck && cyc < 2000) begin
      if (wbReq) wbAll++;
      if (busy && tagSet == 8'd5) begin
        set5Cyc++;
        if (wbReq) begin
          if (wbHs5 < 2) ways5[wbHs5] = wbWay;
          wbHs5++;
        end
        if (wbDoneIn) done5++;
        if (clrReq && done5AtClr < 0) done5AtClr = done5;
      end
      tick();
      cyc++;
    end
    checkOutput("dirty_ack_latency", 32'(cyc), 32'd783);
    checkOutput("dirty_wb_total", 32'(wbAll), 32'd3);
    checkOutput("dirty_wb_set5", 32'(wbHs5), 32'd2);
    checkOutput("dirty_way_first", 32'(ways5[0]), 32'd2);
    checkOutput("dirty_way_second", 32'(ways5[1]), 32'd6);
    checkOutput("dirty_set5_cycles", 32'(set5Cyc), 32'd13);
    checkOutput("dirty_clr_after_done", 32'(done5AtClr), 32'd2);
`ifdef DCACHE_FLUSH_PERF_EN
    checkOutput("dirty_wbcnt", 32'(wbCnt), 32'd3);
`endif

    // Ten-cycle stalls on each grant.
    doReset();
    flushReq = 1'b1;
    tick();
    flushReq = 1'b0;
    stableOk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (outVec() != 5'b11000 || tagSet != 8'd0) stableOk = 1'b0;
      tick();
    end
    checkOutput("stall_tag_hold", 32'(stableOk), 32'd1);
    tagGnt = 1'b1;
    tick();
    tagGnt = 1'b0;
    checkOutput("stall_tag_resume", 32'(outVec()), 32'b10000);
    tbValid = 8'h10; tbDirty = 8'h10;
    tick();
    tbValid = 8'h00; tbDirty = 8'h00;
    stableOk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (outVec() != 5'b10100 || wbWay != 3'd4 || tagSet != 8'd0) stableOk = 1'b0;
      tick();
    end
    checkOutput("stall_wb_hold", 32'(stableOk), 32'd1);
    wbGnt = 1'b1;
    tick();
    wbGnt = 1'b0;
    checkOutput("stall_wb_resume", 32'(outVec()), 32'b10000);
    tbWbDone = 1'b1;
    tick();
    tbWbDone = 1'b0;
    stableOk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (outVec() != 5'b10010 || tagSet != 8'd0) stableOk = 1'b0;
      tick();
    end
    checkOutput("stall_clr_hold", 32'(stableOk), 32'd1);
    clrGnt = 1'b1;
    tick();
    clrGnt = 1'b0;
    checkOutput("stall_clr_resume", 32'(outVec()), 32'b11000);
    checkOutput("stall_next_set", 32'(tagSet), 32'd1);

    // Reset during WB_WAIT at set 100 aborts without ack; a new request restarts at set 0.
    doReset();
    autoMode = 1'b1;
    {tagGnt, wbGnt, clrGnt} = 3'b111;
    flushReq = 1'b1;
    tick();
    flushReq = 1'b0;
    cyc = 0;
    while (!(wbReq && tagSet == 8'd100) && cyc < 2000) begin
      tick();
      cyc++;
    end
    checkOutput("rst_reach_set100", 32'(wbReq && tagSet == 8'd100), 32'd1);
    tick();
    checkOutput("rst_in_wbwait", 32'(outVec()), 32'b10000);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("rst_outs_zero", 32'(outVec()), 32'd0);
    checkOutput("rst_set_zero", 32'(tagSet), 32'd0);
    checkOutput("rst_way_zero", 32'(wbWay), 32'd0);
`ifdef DCACHE_FLUSH_PERF_EN
    checkOutput("rst_wbcnt_zero", 32'(wbCnt), 32'd0);
`endif
    quietOk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (busy || flushAck) quietOk = 1'b0;
      tick();
    end
    checkOutput("rst_no_ack", 32'(quietOk), 32'd1);
    flushReq = 1'b1;
    tick();
    flushReq = 1'b0;
    checkOutput("rst_restart_outs", 32'(outVec()), 32'b11000);
    checkOutput("rst_restart_set", 32'(tagSet), 32'd0);

    // Back-to-back: request held high across the ack.
    doReset();
    autoMode = 1'b1;
    {tagGnt, wbGnt, clrGnt} = 3'b111;
    flushReq = 1'b1;
    tick();
    cyc = 0;
    while (!flushAck && cyc < 2000) begin
      tick();
      cyc++;
    end
    checkOutput("b2b_ack_latency", 32'(cyc), 32'd783);
    tick();
    checkOutput("b2b_idle_gap", 32'(busy), 32'd0);
`ifdef DCACHE_FLUSH_PERF_EN
    checkOutput("b2b_wbcnt_hold", 32'(wbCnt), 32'd3);
`endif
    tick();
    flushReq = 1'b0;
    checkOutput("b2b_restart", 32'(outVec()), 32'b11000);
`ifdef DCACHE_FLUSH_PERF_EN
    checkOutput("b2b_wbcnt_clear", 32'(wbCnt), 32'd0);
`else
    checkOutput("b2b_restart_set", 32'(tagSet), 32'd0);
`endif

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/dcache_flush_ctrl.md
Name: dcache_flush_ctrl

Overview:
- Sequences a full flush of the write-back data cache: walk every set, write back each dirty way, then invalidate the set.
- Sits between the CSR/fence unit (flush requester) and the WB dcache tag array and miss/writeback unit.
- Sized by default for the 32 KiB, 8-way, 128-bit-line dcache configuration (256 sets).

Parameters:
- NUM_SETS, 256, number of cache sets; power of two, ≥2.
- NUM_WAYS, 8, associativity; power of two, ≥2.
- SET_W, $clog2(NUM_SETS), set index width (derived).
- WAY_W, $clog2(NUM_WAYS), way index width (derived).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_req_i  in  1  flush request, level; sampled only in IDLE
- flush_ack_o  out  1  one-cycle pulse: flush complete
- busy_o  out  1  high in every state except IDLE
- tag_req_o  out  1  tag-array read request
- tag_set_o  out  SET_W  set index for tag read and clear
- tag_gnt_i  in  1  tag read granted; data valid the following cycle
- valid_i  in  NUM_WAYS  per-way valid bits of the read set
- dirty_i  in  NUM_WAYS  per-way dirty bits of the read set
- wb_req_o  out  1  writeback request to the miss unit
- wb_way_o  out  WAY_W  way to write back (set = tag_set_o)
- wb_gnt_i  in  1  writeback accepted
- wb_done_i  in  1  one-cycle pulse: writeback finished
- clr_req_o  out  1  invalidate all ways of tag_set_o
- clr_gnt_i  in  1  invalidate accepted

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is synchronous and active-high.
- Reset: FSM to IDLE; set counter 0; dirty mask 0; all outputs 0. Reset mid-flush aborts the flush immediately with no ack.
- Outputs are Moore, decoded from registered state/counters. tag_set_o always equals the set counter.
- IDLE: if flush_req_i, go to RD_TAG with set counter = 0.
- RD_TAG: tag_req_o=1. On tag_gnt_i, go to CHK.
- CHK: capture mask = valid_i & dirty_i. If mask != 0, go to WB; otherwise go to CLR.
- WB: wb_req_o=1; wb_way_o = index of the lowest set bit of the mask. On wb_gnt_i, go to WB_WAIT.
- WB_WAIT: wait for wb_done_i. On wb_done_i, clear that mask bit. If the remaining mask != 0, go to WB; otherwise go to CLR. wb_done_i is ignored in all other states.
- CLR: clr_req_o=1. On clr_gnt_i:
  - if set == NUM_SETS-1, go to DONE;
  - otherwise set+1, go to RD_TAG.
- DONE: flush_ack_o=1 for one cycle, then go to IDLE.
- Request handshake:
  - The requester deasserts flush_req_i in the cycle after it sees the ack.
  - flush_req_i still high in IDLE starts a new flush.
  - flush_req_i dropping mid-flush is ignored; the flush completes.
- Request outputs hold stable until their grant arrives; there is no timeout.
- Latency with all grants tied high and a clean cache:
  - 3 cycles per set;
  - busy_o rises 1 cycle after flush_req_i is sampled;
  - flush_ack_o comes 3*NUM_SETS cycles after busy_o rises (768 cycles by default).
- Each dirty way adds 1 WB cycle plus the WB_WAIT cycles through and including the wb_done_i cycle.
- Set counter does not wrap past NUM_SETS-1. The last set exits via DONE.

Optional Feature:
- Macro: DCACHE_FLUSH_PERF_EN.
- When defined:
  - Adds output flush_wb_cnt_o, width SET_W+WAY_W+1.
  - Cleared on entry to RD_TAG from IDLE.
  - Incremented on each wb_done_i accepted in WB_WAIT.
  - Holds its value after DONE until the next flush starts; reset value 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Clean flush: all grants tied 1, valid_i=dirty_i=0, flush_req_i pulsed. Expect:
  - busy_o high next cycle;
  - 256 clr_req_o handshakes with tag_set_o 0..255 in order;
  - flush_ack_o exactly 768 cycles after busy_o rises;
  - no wb_req_o.
- Dirty set: set 5 returns valid=8'hFF, dirty=8'h44; wb_done_i arrives 4 cycles after each gnt. Expect:
  - wb_way_o=2, then wb_way_o=6, both with tag_set_o=5;
  - clr_req_o only after the second wb_done_i;
  - the set takes 3+2*(1+4) cycles.
- Valid-masking: set 0 returns dirty=8'h01, valid=8'h00. Expect no wb_req_o; go straight to CLR.
- Stalls: tag_gnt_i, wb_gnt_i and clr_gnt_i held low for 10 cycles each. Expect request outputs and tag_set_o/wb_way_o stable throughout; progress resumes the cycle after the grant.
- Reset mid-flush: assert rst_i for 1 cycle during WB_WAIT at set 100. Expect:
  - all outputs 0 next cycle, no ack;
  - a new flush_req_i restarts at set 0.
- Back-to-back and perf counter: hold flush_req_i high across the ack. Expect a second flush to start (busy_o re-rises) 2 cycles after the ack. With DCACHE_FLUSH_PERF_EN and 3 dirty lines in total, expect flush_wb_cnt_o=3 after DONE.
